// File: rtl/fp_flag_accum.sv
// Sticky IEEE-754 exception status for the FIR multiplier: per-flag sticky bits,
// saturating event counters, first-exception capture and a maskable trap request.
module fp_flag_accum #(
  parameter int WFLAG = 5,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_valid,
  input  logic [WFLAG-1:0] flags_in,
  input  logic             clr,
  input  logic             trap_wr,
  input  logic [WFLAG-1:0] trap_en_in,
  input  logic [2:0]       cnt_sel,
  output logic [WFLAG-1:0] sticky,
  output logic [WFLAG-1:0] trap_en,
  output logic             irq,
  output logic [CNTW-1:0]  cnt_out,
  output logic [CNTW-1:0]  res_idx,
  output logic             first_vld,
  output logic [WFLAG-1:0] first_flags,
  output logic [CNTW-1:0]  first_idx
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CAPT = 1'b1
  } cap_state_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == {CNTW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNTW-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [WFLAG-1:0] flags_eff_s;
  logic             hit_s;
  logic [WFLAG-1:0] sticky_nxt_s;
  logic [WFLAG-1:0] trap_en_nxt_s;
  logic [CNTW-1:0]  res_idx_nxt_s;
  logic [CNTW-1:0]  capt_idx_s;
  logic [CNTW-1:0]  cnt_nxt_s [WFLAG];
  logic [CNTW-1:0]  cnt_out_nxt_s;

  logic [WFLAG-1:0] sticky_r;
  logic [WFLAG-1:0] trap_en_r;
  logic             irq_r;
  logic [CNTW-1:0]  cnt_r [WFLAG];
  logic [CNTW-1:0]  cnt_out_r;
  logic [CNTW-1:0]  res_idx_r;
  cap_state_t       state_r;
  logic             first_vld_r;
  logic [WFLAG-1:0] first_flags_r;
  logic [CNTW-1:0]  first_idx_r;

  // Next-state datapath: a clear zeroes the base state, then a valid result is applied on top.
  always_comb begin
    flags_eff_s   = {WFLAG{1'b0}};
    sticky_nxt_s  = sticky_r;
    res_idx_nxt_s = res_idx_r;
    capt_idx_s    = res_idx_r;
    trap_en_nxt_s = trap_en_r;
    cnt_out_nxt_s = {CNTW{1'b0}};
    for (int i = 0; i < WFLAG; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
    end

    if (flag_valid) begin
      flags_eff_s = flags_in;
    end else begin
      flags_eff_s = {WFLAG{1'b0}};
    end

    if (clr) begin
      sticky_nxt_s  = {WFLAG{1'b0}};
      res_idx_nxt_s = {CNTW{1'b0}};
      capt_idx_s    = {CNTW{1'b0}};
      for (int i = 0; i < WFLAG; i++) begin
        cnt_nxt_s[i] = {CNTW{1'b0}};
      end
    end else begin
      capt_idx_s = res_idx_r;
    end

    if (flag_valid) begin
      sticky_nxt_s  = sticky_nxt_s | flags_eff_s;
      res_idx_nxt_s = res_idx_nxt_s + {{(CNTW-1){1'b0}}, 1'b1};
      for (int i = 0; i < WFLAG; i++) begin
        if (flags_eff_s[i]) begin
          cnt_nxt_s[i] = sat_inc(cnt_nxt_s[i]);
        end else begin
          cnt_nxt_s[i] = cnt_nxt_s[i];
        end
      end
    end else begin
      sticky_nxt_s = sticky_nxt_s;
    end

    if (trap_wr) begin
      trap_en_nxt_s = trap_en_in;
    end else begin
      trap_en_nxt_s = trap_en_r;
    end

    // Selector values beyond the flag range read back as zero.
    for (int i = 0; i < WFLAG; i++) begin
      if (cnt_sel == 3'(i)) begin
        cnt_out_nxt_s = cnt_nxt_s[i];
      end else begin
        cnt_out_nxt_s = cnt_out_nxt_s;
      end
    end
  end

  assign hit_s = |flags_eff_s;

  // Status registers; irq is precomputed so it matches the sticky/trap_en it is derived from.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_r  <= {WFLAG{1'b0}};
      trap_en_r <= {WFLAG{1'b0}};
      irq_r     <= 1'b0;
      res_idx_r <= {CNTW{1'b0}};
      cnt_out_r <= {CNTW{1'b0}};
      for (int i = 0; i < WFLAG; i++) begin
        cnt_r[i] <= {CNTW{1'b0}};
      end
    end else begin
      sticky_r  <= sticky_nxt_s;
      trap_en_r <= trap_en_nxt_s;
      irq_r     <= |(sticky_nxt_s & trap_en_nxt_s);
      res_idx_r <= res_idx_nxt_s;
      cnt_out_r <= cnt_out_nxt_s;
      for (int i = 0; i < WFLAG; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // First-exception capture FSM; a clear in CAPT may immediately recapture a same-cycle result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      first_vld_r   <= 1'b0;
      first_flags_r <= {WFLAG{1'b0}};
      first_idx_r   <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            state_r       <= CAPT;
            first_vld_r   <= 1'b1;
            first_flags_r <= flags_eff_s;
            first_idx_r   <= capt_idx_s;
          end else begin
            state_r       <= IDLE;
            first_vld_r   <= 1'b0;
            first_flags_r <= {WFLAG{1'b0}};
            first_idx_r   <= {CNTW{1'b0}};
          end
        end
        CAPT: begin
          if (clr && hit_s) begin
            state_r       <= CAPT;
            first_vld_r   <= 1'b1;
            first_flags_r <= flags_eff_s;
            first_idx_r   <= capt_idx_s;
          end else if (clr) begin
            state_r       <= IDLE;
            first_vld_r   <= 1'b0;
            first_flags_r <= {WFLAG{1'b0}};
            first_idx_r   <= {CNTW{1'b0}};
          end else begin
            state_r       <= CAPT;
            first_vld_r   <= first_vld_r;
            first_flags_r <= first_flags_r;
            first_idx_r   <= first_idx_r;
          end
        end
        default: begin
          state_r       <= IDLE;
          first_vld_r   <= 1'b0;
          first_flags_r <= {WFLAG{1'b0}};
          first_idx_r   <= {CNTW{1'b0}};
        end
      endcase
    end
  end

  assign sticky      = sticky_r;
  assign trap_en     = trap_en_r;
  assign irq         = irq_r;
  assign cnt_out     = cnt_out_r;
  assign res_idx     = res_idx_r;
  assign first_vld   = first_vld_r;
  assign first_flags = first_flags_r;
  assign first_idx   = first_idx_r;

endmodule

// File: tb/tb_fp_flag_accum.sv
// Directed bench for fp_flag_accum with hand-computed expected values.
module tb_fp_flag_accum;

  localparam int WFLAG = 5;
  localparam int CNTW  = 8;

  // Flag bit positions of the multiplier flag vector.
  localparam logic [4:0] F_DIVZERO   = 5'h01;
  localparam logic [4:0] F_INVALID   = 5'h02;
  localparam logic [4:0] F_INEXACT   = 5'h04;
  localparam logic [4:0] F_OVERFLOW  = 5'h08;
  localparam logic [4:0] F_UNDERFLOW = 5'h10;

  logic             clk;
  logic             reset;
  logic             flag_valid;
  logic [WFLAG-1:0] flags_in;
  logic             clr;
  logic             trap_wr;
  logic [WFLAG-1:0] trap_en_in;
  logic [2:0]       cnt_sel;
  logic [WFLAG-1:0] sticky;
  logic [WFLAG-1:0] trap_en;
  logic             irq;
  logic [CNTW-1:0]  cnt_out;
  logic [CNTW-1:0]  res_idx;
  logic             first_vld;
  logic [WFLAG-1:0] first_flags;
  logic [CNTW-1:0]  first_idx;

  int n_vec = 0;
  int n_err = 0;

  fp_flag_accum #(.WFLAG(WFLAG), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flag_valid(flag_valid), .flags_in(flags_in),
    .clr(clr), .trap_wr(trap_wr), .trap_en_in(trap_en_in), .cnt_sel(cnt_sel),
    .sticky(sticky), .trap_en(trap_en), .irq(irq), .cnt_out(cnt_out),
    .res_idx(res_idx), .first_vld(first_vld), .first_flags(first_flags),
    .first_idx(first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WFLAG-1:0] f);
    flag_valid = 1'b1;
    flags_in   = f;
    cyc();
    flag_valid = 1'b0;
    flags_in   = 5'h1F;
  endtask

  initial begin
    reset = 1'b1; flag_valid = 1'b0; flags_in = 5'h00; clr = 1'b0;
    trap_wr = 1'b0; trap_en_in = 5'h00; cnt_sel = 3'd2;
    cyc(); cyc();
    reset = 1'b0;

    check_val("rst_sticky", 32'(sticky), 32'h0);
    check_val("rst_res_idx", 32'(res_idx), 32'h0);
    check_val("rst_first_vld", 32'(first_vld), 32'h0);
    check_val("rst_cnt_out", 32'(cnt_out), 32'h0);

    // Single INEXACT|OVERFLOW result
    push(F_INEXACT | F_OVERFLOW);
    check_val("t1_sticky", 32'(sticky), 32'h0C);
    check_val("t1_cnt_inexact", 32'(cnt_out), 32'h1);
    check_val("t1_res_idx", 32'(res_idx), 32'h1);
    check_val("t1_first_vld", 32'(first_vld), 32'h1);
    check_val("t1_first_idx", 32'(first_idx), 32'h0);
    check_val("t1_first_flags", 32'(first_flags), 32'h0C);
    check_val("t1_irq", 32'(irq), 32'h0);
    cnt_sel = 3'd3; cyc();
    check_val("t1_cnt_overflow", 32'(cnt_out), 32'h1);
    cnt_sel = 3'd1; cyc();
    check_val("t1_cnt_invalid", 32'(cnt_out), 32'h0);
    cnt_sel = 3'd6; cyc();
    check_val("t1_cnt_sel_oob", 32'(cnt_out), 32'h0);

    // Clear, three clean results, INVALID, UNDERFLOW
    clr = 1'b1; cyc(); clr = 1'b0;
    check_val("t2_clr_sticky", 32'(sticky), 32'h0);
    check_val("t2_clr_first_vld", 32'(first_vld), 32'h0);
    check_val("t2_clr_res_idx", 32'(res_idx), 32'h0);
    for (int i = 0; i < 3; i++) push(5'h00);
    check_val("t2_clean_first_vld", 32'(first_vld), 32'h0);
    push(F_INVALID);
    push(F_UNDERFLOW);
    check_val("t2_first_flags", 32'(first_flags), 32'h02);
    check_val("t2_first_idx", 32'(first_idx), 32'h3);
    check_val("t2_res_idx", 32'(res_idx), 32'h5);
    check_val("t2_sticky", 32'(sticky), 32'h12);

    // flag_valid low with garbage flags: nothing moves
    for (int i = 0; i < 10; i++) begin
      flags_in = (i % 2 == 0) ? 5'h1F : 5'bx1x1x;
      cyc();
    end
    check_val("t6_idle_sticky", 32'(sticky), 32'h12);
    check_val("t6_idle_res_idx", 32'(res_idx), 32'h5);
    check_val("t6_idle_first_idx", 32'(first_idx), 32'h3);

    // Trap enable against existing sticky INVALID
    trap_wr = 1'b1; trap_en_in = F_INVALID; cyc(); trap_wr = 1'b0;
    check_val("t4_trap_en", 32'(trap_en), 32'h02);
    check_val("t4_irq_on", 32'(irq), 32'h1);
    trap_wr = 1'b1; trap_en_in = 5'h00; cyc(); trap_wr = 1'b0;
    check_val("t4_irq_off", 32'(irq), 32'h0);
    trap_wr = 1'b1; trap_en_in = F_OVERFLOW; cyc(); trap_wr = 1'b0;
    check_val("t4_irq_masked", 32'(irq), 32'h0);

    // Saturation of INEXACT counter and res_idx wrap
    clr = 1'b1; cyc(); clr = 1'b0;
    cnt_sel = 3'd2;
    for (int i = 0; i < 254; i++) push(F_INEXACT);
    check_val("t3_cnt_254", 32'(cnt_out), 32'hFE);
    for (int i = 0; i < 46; i++) push(F_INEXACT);
    check_val("t3_cnt_sat", 32'(cnt_out), 32'hFF);
    check_val("t3_res_idx_wrap", 32'(res_idx), 32'd44);
    check_val("t3_first_idx", 32'(first_idx), 32'h0);
    check_val("t3_first_flags", 32'(first_flags), 32'h04);

    // Same-cycle clear and OVERFLOW result; trap_en (OVERFLOW) kept
    cnt_sel = 3'd3;
    clr = 1'b1; flag_valid = 1'b1; flags_in = F_OVERFLOW;
    cyc();
    clr = 1'b0; flag_valid = 1'b0;
    check_val("t5_sticky", 32'(sticky), 32'h08);
    check_val("t5_cnt_overflow", 32'(cnt_out), 32'h1);
    check_val("t5_res_idx", 32'(res_idx), 32'h1);
    check_val("t5_first_idx", 32'(first_idx), 32'h0);
    check_val("t5_first_flags", 32'(first_flags), 32'h08);
    check_val("t5_trap_en", 32'(trap_en), 32'h08);
    check_val("t5_irq", 32'(irq), 32'h1);
    cnt_sel = 3'd2; cyc();
    check_val("t5_cnt_inexact", 32'(cnt_out), 32'h0);

    // DIVZERO accumulates like any other bit
    cnt_sel = 3'd0;
    push(F_DIVZERO);
    check_val("t7_divzero_sticky", 32'(sticky), 32'h09);
    check_val("t7_divzero_cnt", 32'(cnt_out), 32'h1);
    check_val("t7_first_kept", 32'(first_flags), 32'h08);

    // Reset in the middle of a burst overrides clr/trap_wr/flag_valid
    flag_valid = 1'b1; flags_in = 5'h1F;
    cyc(); cyc(); cyc();
    reset = 1'b1; clr = 1'b1; trap_wr = 1'b1; trap_en_in = 5'h1F;
    cyc();
    reset = 1'b0; clr = 1'b0; trap_wr = 1'b0; flag_valid = 1'b0;
    check_val("t6_rst_sticky", 32'(sticky), 32'h0);
    check_val("t6_rst_trap_en", 32'(trap_en), 32'h0);
    check_val("t6_rst_irq", 32'(irq), 32'h0);
    check_val("t6_rst_cnt_out", 32'(cnt_out), 32'h0);
    check_val("t6_rst_res_idx", 32'(res_idx), 32'h0);
    check_val("t6_rst_first_vld", 32'(first_vld), 32'h0);
    check_val("t6_rst_first_flags", 32'(first_flags), 32'h0);
    check_val("t6_rst_first_idx", 32'(first_idx), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
